// File: rtl/alu_issue_ctrl.sv
// Issue/capture front end for the combinational ALU: accepts one request, holds the
// operands for a programmable settle time, captures Zlow/Zhigh and presents the result.
module alu_issue_ctrl #(
    parameter int BASIC_WAIT  = 1,
    parameter int MULDIV_WAIT = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_zlow,
    input  logic [31:0] alu_zhigh,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_lo,
    output logic [31:0] res_hi,
    output logic [4:0]  res_op,
    output logic        res_err,
    output logic        busy
);

    localparam logic [4:0] OP_ADD     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b01111;
    localparam logic [4:0] OP_DIV     = 5'b10000;
    localparam logic [7:0] BASIC_CNT  = 8'(BASIC_WAIT);
    localparam logic [7:0] MULDIV_CNT = 8'(MULDIV_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Divide by zero bypasses the ALU, so it needs only a single settle cycle.
    function automatic logic [7:0] settle_cycles(input logic [4:0] op, input logic [31:0] b);
        logic [7:0] w;
        if ((op == OP_DIV) && (b == 32'd0)) begin
            w = 8'd1;
        end else if (is_muldiv(op)) begin
            w = MULDIV_CNT;
        end else begin
            w = BASIC_CNT;
        end
        return w;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        accept_s, capture_s;
    logic [31:0] cap_lo_s, cap_hi_s;
    logic        cap_err_s;

    logic [31:0] alu_a_r, alu_b_r;
    logic [4:0]  alu_op_r;
    logic [31:0] res_lo_r, res_hi_r;
    logic [4:0]  res_op_r;
    logic        res_err_r;
    logic        req_ready_r, busy_r, res_valid_r;

    // Next-state and counter logic for the IDLE/SETTLE/RESULT sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s    = 1'b1;
                    cnt_nxt_s   = settle_cycles(req_op, req_b);
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r <= 8'd1) begin
                    cnt_nxt_s   = 8'd0;
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESULT;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: begin
                cnt_nxt_s   = 8'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result word selection at capture time, including the divide-by-zero override.
    always_comb begin
        cap_lo_s  = alu_zlow;
        cap_hi_s  = 32'd0;
        cap_err_s = 1'b0;
        if ((alu_op_r == OP_DIV) && (alu_b_r == 32'd0)) begin
            cap_lo_s  = 32'hFFFF_FFFF;
            cap_hi_s  = alu_a_r;
            cap_err_s = 1'b1;
        end else if (is_muldiv(alu_op_r)) begin
            cap_hi_s  = alu_zhigh;
        end else begin
            cap_hi_s  = 32'd0;
        end
    end

    // State, counter and registered status decodes.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            res_valid_r <= (state_nxt_s == ST_RESULT);
        end
    end

    // Operand latch on accept and result capture at the end of settle.
    always_ff @(posedge clock) begin
        if (clear) begin
            alu_a_r   <= 32'd0;
            alu_b_r   <= 32'd0;
            alu_op_r  <= OP_ADD;
            res_lo_r  <= 32'd0;
            res_hi_r  <= 32'd0;
            res_op_r  <= 5'd0;
            res_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_a_r  <= req_a;
                alu_b_r  <= req_b;
                alu_op_r <= req_op;
            end
            if (capture_s) begin
                res_lo_r  <= cap_lo_s;
                res_hi_r  <= cap_hi_s;
                res_op_r  <= alu_op_r;
                res_err_r <= cap_err_s;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign busy      = busy_r;
    assign res_valid = res_valid_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign res_lo    = res_lo_r;
    assign res_hi    = res_hi_r;
    assign res_op    = res_op_r;
    assign res_err   = res_err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a settle-aware ALU stand-in, a transaction-level
// reference model compared every cycle, directed literal cases, then randomized traffic.
module tb_alu_issue_ctrl;

    localparam int BW = 1;
    localparam int MW = 4;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    logic        clock = 1'b0;
    logic        clear, req_valid, req_ready, res_valid, res_ready, res_err, busy;
    logic [4:0]  req_op, alu_op, res_op;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_zlow, alu_zhigh, res_lo, res_hi;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    alu_issue_ctrl #(.BASIC_WAIT(BW), .MULDIV_WAIT(MW)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_zlow(alu_zlow), .alu_zhigh(alu_zhigh),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lo(res_lo), .res_hi(res_hi), .res_op(res_op),
        .res_err(res_err), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] pa, pb;
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        case (op)
            OP_SUB: return {a ^ b, a - b};
            OP_MUL: begin
                pa = {{32{a[31]}}, a};
                pb = {{32{b[31]}}, b};
                return 64'(pa * pb);
            end
            OP_DIV: begin
                if (b == 32'd0) return 64'd0;
                if (b == 32'hFFFF_FFFF) return {32'd0, 32'd0 - a};
                sa = a; sb = b;
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
            default: return {a ^ b, a + b};
        endcase
    endfunction

    // ALU stand-in: gives the true answer only once its inputs have been stable long enough.
    logic [31:0] prev_a, prev_b;
    logic [4:0]  prev_op;
    int          age = 0;
    initial begin alu_zlow = 32'd0; alu_zhigh = 32'd0; end
    always @(negedge clock) begin
        logic [63:0] r;
        int need;
        if (alu_a !== prev_a || alu_b !== prev_b || alu_op !== prev_op) begin
            age = 1; prev_a = alu_a; prev_b = alu_b; prev_op = alu_op;
        end else if (age < 1000) begin
            age++;
        end
        need = (alu_op == OP_MUL || alu_op == OP_DIV) ? MW : BW;
        r = alu_ref(alu_op, alu_a, alu_b);
        if (age >= need) {alu_zhigh, alu_zlow} = r;
        else             {alu_zhigh, alu_zlow} = ~r;
    end

    // Transaction-level reference: one outstanding op, result visible from edge accept+W.
    bit          m_pending = 1'b0;
    int          m_done_at = 0;
    logic [31:0] m_alu_a = 32'd0, m_alu_b = 32'd0;
    logic [4:0]  m_alu_op = OP_ADD;
    logic [31:0] m_lo = 32'd0, m_hi = 32'd0, p_lo, p_hi;
    logic [4:0]  m_op = 5'd0, p_op;
    logic        m_err = 1'b0, p_err;
    always @(posedge clock) begin
        logic [63:0] r;
        int w;
        cyc++;
        if (clear) begin
            m_pending = 1'b0;
            m_alu_a = 32'd0; m_alu_b = 32'd0; m_alu_op = OP_ADD;
            m_lo = 32'd0; m_hi = 32'd0; m_op = 5'd0; m_err = 1'b0;
        end else if (!m_pending) begin
            if (req_valid) begin
                m_pending = 1'b1;
                m_alu_a = req_a; m_alu_b = req_b; m_alu_op = req_op;
                p_op = req_op;
                if (req_op == OP_DIV && req_b == 32'd0) begin
                    w = 1; p_lo = 32'hFFFF_FFFF; p_hi = req_a; p_err = 1'b1;
                end else begin
                    w = (req_op == OP_MUL || req_op == OP_DIV) ? MW : BW;
                    r = alu_ref(req_op, req_a, req_b);
                    p_lo = r[31:0];
                    p_hi = (req_op == OP_MUL || req_op == OP_DIV) ? r[63:32] : 32'd0;
                    p_err = 1'b0;
                end
                m_done_at = cyc + w;
            end
        end else if (cyc == m_done_at) begin
            m_lo = p_lo; m_hi = p_hi; m_op = p_op; m_err = p_err;
        end else if (cyc > m_done_at && res_ready) begin
            m_pending = 1'b0;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (cyc > 0) begin
            chk("req_ready", req_ready, !m_pending);
            chk("busy", busy, m_pending);
            chk("res_valid", res_valid, m_pending && (cyc >= m_done_at));
            chk("alu_a", alu_a, m_alu_a);
            chk("alu_b", alu_b, m_alu_b);
            chk("alu_op", alu_op, m_alu_op);
            chk("res_lo", res_lo, m_lo);
            chk("res_hi", res_hi, m_hi);
            chk("res_op", res_op, m_op);
            chk("res_err", res_err, m_err);
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int k);
        int t = 0;
        while (req_ready !== 1'b1 && t < 50) begin @(negedge clock); t++; end
        chk("issue_ready_wait", req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clock); #1;
        k = cyc;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        int t = 0;
        while (res_valid !== 1'b1 && t < 300) begin @(negedge clock); t++; end
        chk("result_wait", res_valid, 1'b1);
        lat = cyc - k;
    endtask

    task automatic release_res(input int stall, input bit poke, input logic [31:0] hold_lo);
        for (int i = 0; i < stall; i++) begin
            chk("stall_req_ready", req_ready, 1'b0);
            chk("stall_res_lo", res_lo, hold_lo);
            if (poke && i == 1) begin
                req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd1; req_b = 32'd1;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, lat, r;
        clear = 1'b1; req_valid = 1'b0; req_op = 5'd0; req_a = 32'd0; req_b = 32'd0; res_ready = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        chk("rst_alu_op", alu_op, 5'b00011);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);

        issue(OP_ADD, 32'd5, 32'd7, k); wait_valid(k, lat);
        chk("add_latency", lat, 1); chk("add_lo", res_lo, 32'd12);
        chk("add_hi", res_hi, 32'd0); chk("add_err", res_err, 1'b0);
        release_res(0, 1'b0, 32'd12);

        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, k); wait_valid(k, lat);
        chk("mul_latency", lat, 4); chk("mul_hi", res_hi, 32'd1);
        chk("mul_lo", res_lo, 32'd0); chk("mul_op", res_op, OP_MUL);
        release_res(0, 1'b0, 32'd0);

        issue(OP_DIV, 32'd9, 32'd0, k); wait_valid(k, lat);
        chk("div0_latency", lat, 1); chk("div0_err", res_err, 1'b1);
        chk("div0_lo", res_lo, 32'hFFFF_FFFF); chk("div0_hi", res_hi, 32'd9);
        release_res(1, 1'b0, 32'hFFFF_FFFF);

        issue(OP_DIV, 32'd17, 32'd5, k); wait_valid(k, lat);
        chk("div_latency", lat, 4); chk("div_lo", res_lo, 32'd3);
        chk("div_hi", res_hi, 32'd2); chk("div_err", res_err, 1'b0);
        release_res(0, 1'b0, 32'd3);

        issue(OP_SUB, 32'd3, 32'd10, k); wait_valid(k, lat);
        chk("sub_lo", res_lo, 32'hFFFF_FFF9); chk("sub_hi", res_hi, 32'd0);
        release_res(3, 1'b1, 32'hFFFF_FFF9);

        issue(5'b11111, 32'd1, 32'd2, k); wait_valid(k, lat);
        chk("unk_latency", lat, 1); chk("unk_lo", res_lo, 32'd3); chk("unk_hi", res_hi, 32'd0);
        release_res(0, 1'b0, 32'd3);

        issue(OP_MUL, 32'd7, 32'd6, k);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_req_ready", req_ready, 1'b1); chk("clr_busy", busy, 1'b0);
        chk("clr_alu_op", alu_op, 5'b00011); chk("clr_res_lo", res_lo, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("clr_no_valid", res_valid, 1'b0);
            @(negedge clock);
        end

        for (int i = 0; i < 2500; i++) begin
            clear = ($urandom_range(0, 99) == 0);
            req_valid = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            req_op = (r < 3) ? OP_ADD : (r == 3) ? OP_SUB : (r < 6) ? OP_MUL :
                     (r < 8) ? OP_DIV : 5'($urandom_range(0, 31));
            req_a = $urandom;
            req_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            res_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock);
        end
        clear = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
        repeat (10) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential front end that issues operations to the combinational ALU and captures its results. It accepts one request (op, A, B) over a valid/ready handshake and drives the ALU operand and opcode inputs. It holds them stable for a programmable settle time, so the long ripple-carry, Booth and divide paths resolve before it samples `Zlowout`/`Zhighout` into result registers. It then presents the result over a second valid/ready handshake, making it the initiator and consumer on the ALU's port boundary.

## Interface
- `BASIC_WAIT`, 1: settle cycles for every opcode except multiply and divide. Legal range 1–255.
- `MULDIV_WAIT`, 4: settle cycles for multiply `5'b01111` and divide `5'b10000`. Legal range 1–255.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `clear`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  5  ALU opcode.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `alu_a`  out  32  registered operand A to the ALU.
- `alu_b`  out  32  registered operand B to the ALU.
- `alu_op`  out  5  registered opcode to the ALU.
- `alu_zlow`  in  32  ALU `Zlowout`.
- `alu_zhigh`  in  32  ALU `Zhighout`.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts the result.
- `res_lo`  out  32  captured low word: quotient for divide, low product for multiply.
- `res_hi`  out  32  captured high word: remainder for divide, high product for multiply, 0 otherwise.
- `res_op`  out  5  opcode of the captured result.
- `res_err`  out  1  divide by zero.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, SETTLE and RESULT.
- **IDLE:** `req_ready`=1. When `req_valid`=1, the block latches `req_a`, `req_b` and `req_op` into `alu_a`, `alu_b` and `alu_op`. It loads the 8-bit counter `cnt` with W and goes to SETTLE.
  - W = `MULDIV_WAIT` for ops 01111 and 10000.
  - W = 1 for divide with `req_b`=0.
  - W = `BASIC_WAIT` for every other op.
- **SETTLE:** `cnt` decrements each cycle. In the cycle where `cnt`=1, the block samples the result registers and goes to RESULT.
  - `res_lo` ← `alu_zlow`.
  - `res_hi` ← `alu_zhigh` for ops 01111 and 10000; `res_hi` ← 0 for all other ops.
  - `res_op` ← `alu_op`.
  - `res_err` ← 0.
- **Divide by zero** (op 10000 with `alu_b`=0): the capture forces `res_lo`=32'hFFFF_FFFF, `res_hi`=`alu_a` and `res_err`=1, ignoring the ALU outputs.
- **RESULT:** `res_valid`=1. The result outputs hold stable until `res_ready`=1. On that handshake the block returns to IDLE.
- **Unknown or unlisted opcodes** pass to the ALU unchanged and use `BASIC_WAIT`, with `res_hi`=0. The ALU treats them as add.
- `alu_a`, `alu_b` and `alu_op` change only on request acceptance. They hold their values through SETTLE, RESULT and IDLE.
- There is no overlap: a new request is never accepted while a result is pending.

## Timing
- **Reset values**, applied when `clear`=1 at a rising edge:
  - state IDLE;
  - `req_ready`=1;
  - `alu_a`=0, `alu_b`=0, `alu_op`=5'b00011;
  - `res_valid`=0, `res_lo`=0, `res_hi`=0, `res_op`=0, `res_err`=0;
  - `busy`=0;
  - `cnt`=0.
- `clear` overrides every other input in the same cycle.
- **Latency:** if the request is accepted at edge k, `res_valid` rises after edge k+W. For W=1, `res_valid` is high in the cycle immediately after the first SETTLE cycle.
- **Throughput:** one operation per W+2 cycles at best, counting one IDLE accept cycle, W SETTLE cycles and one RESULT cycle with `res_ready`=1.
- `req_ready` is a registered state decode, not combinational on `req_valid`. `res_valid` is the RESULT-state decode.
- **Clear mid-SETTLE or mid-RESULT:** the in-flight operation is discarded and no `res_valid` pulse is produced. `req_ready`=1 in the next cycle.
- `req_valid` while busy is ignored. The requester must hold its request until `req_ready`=1.
- **Back-pressure:** `res_ready`=0 for any number of cycles leaves `res_*` and `alu_*` unchanged.

## Test plan
- **Add:** op 00011, A=5, B=7, `BASIC_WAIT`=1 → `res_valid` after edge k+1, `res_lo`=12, `res_hi`=0, `res_err`=0.
- **Multiply:** op 01111, A=B=32'h0001_0000, `MULDIV_WAIT`=4 → `res_valid` exactly 4 edges after accept, `res_hi`=1, `res_lo`=0.
- **Divide by zero:** op 10000, A=9, B=0 → after 1 settle cycle, `res_err`=1, `res_lo`=32'hFFFF_FFFF, `res_hi`=9. Then op 10000, A=17, B=5 → `res_lo`=3, `res_hi`=2, `res_err`=0.
- **Back-pressure:** sub op 00100, A=3, B=10, `res_ready` low for 3 cycles → `res_lo`=32'hFFFF_FFF9 stable, `req_ready`=0 throughout, and a `req_valid` pulse during the stall is ignored.
- **Clear mid-SETTLE:** issue multiply, assert `clear` on the second SETTLE cycle → no `res_valid`, all outputs at reset values, `req_ready`=1 in the next cycle.
